// File: rtl/addsub_serial_if.sv
// Handshake and data bundle between the calculator control FSM (master)
// and the bit-serial add/subtract unit (slave).
interface addsub_serial_if #(parameter int WIDTH = 4);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             busy;
  logic             done;
  logic [WIDTH+1:0] result;
  logic             sign;
  logic [WIDTH:0]   mag;

  modport master (
    output start, mode, a_data, b_data,
    input  busy, done, result, sign, mag
  );

  modport slave (
    input  start, mode, a_data, b_data,
    output busy, done, result, sign, mag
  );
endinterface

// File: rtl/addsub_serial.sv
// Bit-serial unsigned add/subtract: one full-adder slice walks WIDTH+2 bits LSB
// first, then publishes a two's-complement word plus sign/magnitude.
module addsub_serial #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  addsub_serial_if.slave  bus
);

  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(RW);
  localparam logic [CW-1:0] LAST_BIT = CW'(RW - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [RW-1:0]   a_sr;
  logic [RW-1:0]   b_sr;
  logic [RW-1:0]   res_sr;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            mode_q;

  logic            b_eff;
  logic            sum_bit;
  logic            carry_nxt;
  logic            last_bit;
  logic [WIDTH:0]  neg_mag;

  logic            done_q;
  logic [RW-1:0]   result_q;
  logic            sign_q;
  logic [WIDTH:0]  mag_q;

  // Operand registers shift in zeros, so the high bits see a=b=0 and b_eff
  // collapses to mode_q, which sign-extends the subtraction.
  assign b_eff     = b_sr[0] ^ mode_q;
  assign sum_bit   = a_sr[0] ^ b_eff ^ carry;
  assign carry_nxt = (a_sr[0] & b_eff) | (a_sr[0] & carry) | (b_eff & carry);
  assign last_bit  = (cnt == LAST_BIT);
  // Low bits of -x depend only on low bits of x, so WIDTH+1 bits suffice.
  assign neg_mag   = -res_sr[WIDTH:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last_bit)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sr   <= RW'(bus.a_data);
          b_sr   <= RW'(bus.b_data);
          mode_q <= bus.mode;
          carry  <= bus.mode;
          cnt    <= '0;
        end
        CALC: begin
          res_sr <= {sum_bit, res_sr[RW-1:1]};
          a_sr   <= {1'b0, a_sr[RW-1:1]};
          b_sr   <= {1'b0, b_sr[RW-1:1]};
          carry  <= carry_nxt;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
    end else begin
      done_q <= (state == FIN);
      if (state == FIN) begin
        result_q <= res_sr;
        sign_q   <= res_sr[RW-1];
        mag_q    <= res_sr[RW-1] ? neg_mag : res_sr[WIDTH:0];
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.sign   = sign_q;
  assign bus.mag    = mag_q;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, bit-serial unsigned add/subtract unit for the multi-digit calculator datapath. It generalises the combinational 4-bit subtractor. A single full-adder slice iterates over the operand bits, and the unit selects add or subtract per operation. It returns a two's-complement result plus a sign/magnitude form for the display stage. A START/BUSY/DONE handshake connects it to the calculator control FSM.

## Interface
- WIDTH, 4, operand width in bits (≥2); result width is WIDTH+2.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE.
- MODE  in  1  0 = A_DATA + B_DATA, 1 = A_DATA − B_DATA; captured with START.
- A_DATA  in  WIDTH  unsigned operand A (minuend/augend); captured with START.
- B_DATA  in  WIDTH  unsigned operand B (subtrahend/addend); captured with START.
- BUSY  out  1  high while an operation is in progress (states CALC, FIN).
- DONE  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- RESULT  out  WIDTH+2  two's-complement result.
- SIGN  out  1  RESULT[WIDTH+1].
- MAG  out  WIDTH+1  absolute value of RESULT.

## Operation
- States: IDLE, CALC, FIN.
- **IDLE:**
  - If START=1 at an edge:
    - Load operand shift registers with A_DATA and B_DATA, each zero-extended to WIDTH+2 bits.
    - Latch MODE. Set carry = MODE. Clear the bit counter.
    - Go to CALC.
  - Otherwise stay in IDLE.
- **CALC:** each edge processes bit i = counter:
  - s = a_i ^ (b_i ^ MODE) ^ carry.
  - carry ← majority(a_i, b_i ^ MODE, carry).
  - s is shifted into the result shift register (LSB first). Both operand registers shift right.
  - Bits above WIDTH−1 use a_i = b_i = 0, so b_i ^ MODE = MODE. This gives sign extension in subtract mode.
  - After the edge that processes bit WIDTH+1, go to FIN.
  - The final carry-out is discarded. Overflow is impossible: the add range is 0..2^(WIDTH+1)−2 and the subtract range is −(2^WIDTH−1)..2^WIDTH−1.
- **FIN:** one edge:
  - RESULT ← assembled word; SIGN ← its MSB.
  - MAG ← SIGN ? (−word)[WIDTH:0] : word[WIDTH:0]. This is a combinational negate of the internal register.
  - DONE ← 1; go to IDLE.
- RESULT, SIGN and MAG change only at the FIN edge and hold until the next FIN edge.
- START while BUSY=1 is ignored. Operands and MODE may change freely after capture.
- START in the cycle DONE is high is accepted (state is IDLE). Back-to-back operations are therefore legal with no idle gap.
- **Reset (RST_N=0), at any time, including mid-CALC:**
  - State is forced to IDLE and the current operation is aborted with no DONE.
  - Counter, carry and shift registers are cleared.
  - RESULT=0, SIGN=0, MAG=0, BUSY=0, DONE=0.

## Timing
- START sampled at edge k → BUSY=1 after edge k.
- CALC occupies edges k+1 … k+WIDTH+2. FIN is edge k+WIDTH+3.
- DONE=1 and outputs valid for the cycle after edge k+WIDTH+3. Latency is WIDTH+3 cycles, i.e. 7 for WIDTH=4.
- BUSY falls at the same edge DONE rises. DONE falls at the next edge.
- Throughput: one operation per WIDTH+3 cycles.
- Reset deassertion: the first START can be sampled at the first rising edge with RST_N=1.

## Test plan
- **WIDTH=4, subtract, positive result:** MODE=1, A=9, B=7, START pulse → DONE exactly 7 cycles later; RESULT=6'b000010, SIGN=0, MAG=2.
- **WIDTH=4, subtract, negative results:**
  - MODE=1, A=3, B=9 → RESULT=6'b111010, SIGN=1, MAG=6.
  - MODE=1, A=0, B=15 → RESULT=6'b110001, MAG=15.
- **WIDTH=4, add extremes:**
  - MODE=0, A=15, B=15 → RESULT=30, SIGN=0, MAG=30.
  - MODE=0, A=0, B=0 → RESULT=0.
  - Exhaustive sweep of all 512 (A, B, MODE) combinations matches a reference model.
- **Handshake:**
  - START pulsed again during BUSY with different operands → ignored; the first result is unchanged and only one DONE occurs.
  - START in the DONE cycle → second DONE exactly 7 cycles later.
- **Reset mid-operation:** assert RST_N=0 three cycles into CALC → BUSY, DONE, RESULT, SIGN and MAG are all 0 immediately. After release, a new 5−5 operation gives RESULT=0 with normal latency.
- **WIDTH=8:** MODE=1, A=0, B=255 → DONE after 11 cycles; RESULT=10'b1100000001, SIGN=1, MAG=255.
